// File: rtl/id_scoreboard_pkg.sv
// Shared definitions for the ID-stage register scoreboard: register address
// width, default pending-counter width and the issue FSM encoding.
package id_scoreboard_pkg;

  localparam int unsigned REG_AW      = 5;
  localparam int unsigned NUM_REGS    = 1 << REG_AW;
  localparam int unsigned CNT_W_DEF   = 2;
  localparam int unsigned STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } sb_state_e;

endpackage

// File: rtl/id_scoreboard_sb_cnt.sv
// Per-register pending-write counter: saturating up/down with a same-cycle
// writeback bypass on the pending flag and an underflow indication.
module sb_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic inc,
  input  logic dec,
  output logic pending,
  output logic full,
  output logic underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_ok;

  always_comb begin
    dec_ok    = dec && (cnt_q != '0);
    underflow = dec && (cnt_q == '0);
    // Still pending after any writeback retiring in this same cycle.
    pending   = (cnt_q != '0) && !(dec && (cnt_q == CNT_ONE));
    full      = (cnt_q == CNT_MAX);
    cnt_d     = cnt_q;
    if (en) begin
      if (inc && !dec_ok && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (dec_ok && !inc) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage register scoreboard: tracks in-flight writes to x1..x31, stalls
// dependent or over-subscribed issues and inserts bubbles on stall and flush.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   id_valid,
  input  logic                   id_rs1_re,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic                   id_rs2_re,
  input  logic [REG_AW-1:0]      id_rs2,
  input  logic                   id_rd_we,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   wb_valid,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic                   flush_in,
  output logic                   id_ready,
  output logic                   stall_out,
  output logic                   bubble_out,
  output logic [1:0]             state_out,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   wb_err
);

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

  sb_state_e              state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   wb_err_q, wb_err_d;

  logic [NUM_REGS-1:0] pend_vec, full_vec, under_vec;
  logic                active, hazard, block, ready_c, stall_c, issue_wr;

  // x0 is never tracked: it is always ready and never reports underflow.
  assign pend_vec[0]  = 1'b0;
  assign full_vec[0]  = 1'b0;
  assign under_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk_in),
      .rst_n     (rst_in),
      .en        (rdy_in),
      .inc       (issue_wr && (id_rd == REG_AW'(r))),
      .dec       (wb_valid && (wb_rd == REG_AW'(r))),
      .pending   (pend_vec[r]),
      .full      (full_vec[r]),
      .underflow (under_vec[r])
    );
  end

  always_comb begin
    active   = rst_in && rdy_in;
    hazard   = (id_rs1_re && pend_vec[id_rs1]) || (id_rs2_re && pend_vec[id_rs2]);
    block    = id_rd_we && full_vec[id_rd];
    ready_c  = active && id_valid && !flush_in && !hazard && !block
               && (state_q != ST_FLUSH);
    stall_c  = active && id_valid && !ready_c && (state_q != ST_FLUSH);
    issue_wr = ready_c && id_rd_we;
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    wb_err_d    = wb_err_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d = ST_FLUSH;
      end else begin
        unique case (state_q)
          ST_RUN:   if (id_valid && (hazard || block)) state_d = ST_STALL;
          ST_STALL: if (!id_valid || ready_c) state_d = ST_RUN;
          default:  state_d = ST_RUN;
        endcase
      end
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + STALL_ONE;
      end
      if (|under_vec) begin
        wb_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign id_ready   = ready_c;
  assign stall_out  = stall_c;
  assign bubble_out = stall_c || (active && (state_q == ST_FLUSH));
  assign state_out  = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign wb_err     = wb_err_q;

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 SHALL have port clk_in, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have port rst_in, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port rdy_in, input, 1, global enable; 0 freezes all state.
REQ-004 SHALL have ports id_valid (1), id_rs1_re (1), id_rs1 (5), id_rs2_re (1), id_rs2 (5), id_rd_we (1), id_rd (5), inputs, decoded instruction in ID.
REQ-005 SHALL have ports wb_valid (1), wb_rd (5), inputs, register writeback retiring one pending write.
REQ-006 SHALL have port flush_in, input, 1, branch/jump redirect from EX.
REQ-007 SHALL have outputs id_ready (1), issue accepted this cycle; stall_out (1), hold PC and IF/ID; bubble_out (1), insert NOP into ID/EX.
REQ-008 SHALL have outputs state_out (2), FSM state; stall_cnt (16), stall-cycle count; wb_err (1), sticky underflow flag.
REQ-009 SHALL have parameter CNT_W, default 2, width of per-register pending counter.

Function
REQ-010 SHALL keep one pending counter per register x1..x31; x0 never tracked, always ready.
REQ-011 SHALL flag source hazard when rsN_re=1, rsN!=0 and effective count !=0, where effective count = cnt[rsN] minus 1 if wb_valid and wb_rd==rsN this cycle.
REQ-012 SHALL flag structural block when id_rd_we=1, id_rd!=0 and cnt[id_rd]==2^CNT_W-1.
REQ-013 SHALL assert id_ready = rdy_in & id_valid & !flush_in & !hazard & !block & state!=FLUSH, combinationally.
REQ-014 SHALL, on issue with id_rd_we=1 and id_rd!=0, increment cnt[id_rd] at the next edge.
REQ-015 SHALL, on wb_valid=1 and wb_rd!=0, decrement cnt[wb_rd]; issue and writeback to same register in one cycle leave it unchanged.
REQ-016 SHALL ignore writeback to a zero counter and set wb_err, cleared only by reset.
REQ-017 SHALL implement FSM RUN(0), STALL(1), FLUSH(2).
REQ-018 RUN: id_valid with hazard/block -> STALL; else stay.
REQ-019 STALL: hold until hazard and block clear, then issue that cycle -> RUN; id_valid dropping -> RUN.
REQ-020 Any state: flush_in=1 -> FLUSH; FLUSH lasts exactly one cycle -> RUN; flush has priority over issue.
REQ-021 SHALL drive stall_out=1 and bubble_out=1 when id_valid=1 and id_ready=0 outside FLUSH; in FLUSH bubble_out=1, stall_out=0.
REQ-022 SHALL increment stall_cnt each cycle stall_out=1, saturating at 16'hFFFF.
REQ-023 SHALL, when rdy_in=0, hold counters, FSM, stall_cnt, wb_err; id_ready=0, stall_out=0, bubble_out=0.
REQ-024 Scoreboard latency: writeback in cycle N releases dependent issue in cycle N (same-cycle bypass per REQ-011).

Reset
REQ-025 rst_in=0 SHALL immediately clear all counters, state=RUN, stall_cnt=0, wb_err=0.
REQ-026 During reset id_ready, stall_out, bubble_out SHALL be 0; reset mid-stall abandons the stall, no issue.
REQ-027 First edge after rst_in rises SHALL behave as RUN with empty scoreboard.

Structure
REQ-028 FSM encodings, CNT_W default and 5-bit register address width SHALL live in the shared define file.
REQ-029 Per-register up/down saturating counter SHALL be sub-module sb_cnt, instantiated for x1..x31.

Verification
REQ-030 Issue addi x5 (rd_we, rd=5), next cycle add x6,x5,x0 -> id_ready=0, stall_out=1, state=STALL until wb_rd=5, then issue same cycle, stall_cnt=count of stalled cycles.
REQ-031 Three issues writing x7 without writeback, fourth writing x7 -> blocked (cnt=3); one wb_rd=7 -> fourth issues.
REQ-032 flush_in=1 with hazard-free id_valid -> id_ready=0, bubble_out=1, state=FLUSH one cycle, then RUN.
REQ-033 wb_valid=1, wb_rd=9 with cnt[9]=0 -> wb_err=1, counters unchanged; rs1=0 read never stalls.
REQ-034 Pending x3, rdy_in=0 for 4 cycles with wb_valid=1, wb_rd=3 -> cnt[3] unchanged, stall_cnt unchanged.
REQ-035 rst_in=0 mid-STALL with cnt[5]=2 -> all outputs 0, cnt[5]=0, state=RUN without waiting for clock.
